// File: rtl/rmii_rx_framer_if.sv
// RMII receive pins plus the framed byte/status stream of the RX framer.
// master is the framer side; slave is the PHY-model/consumer side.
interface rmii_rx_framer_if;
  logic        crsdv;
  logic [1:0]  rxd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        frame_done;
  logic        crc_ok;
  logic        align_err;
  logic        len_err;
  logic [10:0] frame_len;

  modport master (
    input  crsdv, rxd,
    output rx_data, rx_valid, rx_last, frame_done, crc_ok, align_err, len_err, frame_len
  );

  modport slave (
    output crsdv, rxd,
    input  rx_data, rx_valid, rx_last, frame_done, crc_ok, align_err, len_err, frame_len
  );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD detection, dibit-to-byte packing with a
// one-byte holdback so the final FCS byte can carry rx_last, and CRC-32 status.
module rmii_rx_framer #(
  parameter int MAX_LEN      = 1522,
  parameter int MIN_PREAMBLE = 8
) (
  input logic            clk,
  input logic            rstn,
  rmii_rx_framer_if.master bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FRAME_END, DROP} state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [3:0]  MIN_PRE_C   = 4'(MIN_PREAMBLE);

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state, state_d;
  logic        crsdv_q;
  logic [1:0]  rxd_q;
  logic [3:0]  pre_cnt, pre_cnt_d;
  logic [1:0]  dib_idx, dib_idx_d;
  logic [5:0]  shift, shift_d;
  logic [10:0] byte_cnt, byte_cnt_d;
  logic [31:0] crc, crc_d;
  logic [7:0]  held, held_d;
  logic        held_vld, held_vld_d;
  logic        align_pend, align_pend_d;
  logic        len_pend, len_pend_d;
  logic [7:0]  new_byte;

  logic [7:0]  data_r, data_d;
  logic        valid_r, valid_d;
  logic        last_r, last_d;
  logic        done_r, done_d;
  logic        crc_ok_r, crc_ok_d;
  logic        align_r, align_d;
  logic        len_r, len_d;
  logic [10:0] flen_r, flen_d;

  // Earlier dibits sit in shift[1:0], [3:2], [5:4]; the current one tops the byte.
  assign new_byte = {rxd_q, shift};

  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    state_d      = state;
    pre_cnt_d    = pre_cnt;
    dib_idx_d    = dib_idx;
    shift_d      = shift;
    byte_cnt_d   = byte_cnt;
    crc_d        = crc;
    held_d       = held;
    held_vld_d   = held_vld;
    align_pend_d = align_pend;
    len_pend_d   = len_pend;
    data_d       = data_r;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    done_d       = 1'b0;
    crc_ok_d     = crc_ok_r;
    align_d      = align_r;
    len_d        = len_r;
    flen_d       = flen_r;

    unique case (state)
      IDLE: begin
        if (crsdv_q && rxd_q == 2'b01) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 4'd1;
        end
      end

      PREAMBLE: begin
        if (!crsdv_q) begin
          state_d = IDLE;
        end else if (rxd_q == 2'b01) begin
          if (pre_cnt != 4'hF) pre_cnt_d = pre_cnt + 4'd1;
        end else if (rxd_q == 2'b11 && pre_cnt >= MIN_PRE_C) begin
          state_d      = DATA;
          dib_idx_d    = 2'd0;
          byte_cnt_d   = 11'd0;
          crc_d        = CRC_INIT;
          held_vld_d   = 1'b0;
          align_pend_d = 1'b0;
          len_pend_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (!crsdv_q) begin
          // Carrier gone: flush the held byte as the frame's last byte.
          if (held_vld) begin
            data_d  = held;
            valid_d = 1'b1;
            last_d  = 1'b1;
          end
          held_vld_d   = 1'b0;
          align_pend_d = (dib_idx != 2'd0);
          state_d      = FRAME_END;
        end else begin
          dib_idx_d = dib_idx + 2'd1;
          shift_d   = {rxd_q, shift[5:2]};
          if (dib_idx == 2'd3) begin
            if (byte_cnt == MAX_LEN_C) begin
              if (held_vld) begin
                data_d  = held;
                valid_d = 1'b1;
                last_d  = 1'b1;
              end
              held_vld_d = 1'b0;
              len_pend_d = 1'b1;
              state_d    = FRAME_END;
            end else begin
              byte_cnt_d = byte_cnt + 11'd1;
              crc_d      = crc_byte(crc, new_byte);
              if (held_vld) begin
                data_d  = held;
                valid_d = 1'b1;
              end
              held_d     = new_byte;
              held_vld_d = 1'b1;
            end
          end
        end
      end

      FRAME_END: begin
        done_d   = 1'b1;
        crc_ok_d = !align_pend && !len_pend && (crc == CRC_RESIDUE);
        align_d  = align_pend;
        len_d    = len_pend;
        flen_d   = byte_cnt;
        state_d  = len_pend ? DROP : IDLE;
      end

      DROP: begin
        if (!crsdv_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so every register updates together at the edge.
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crsdv_q    <= 1'b0;
      rxd_q      <= 2'b00;
      pre_cnt    <= 4'd0;
      dib_idx    <= 2'd0;
      shift      <= 6'd0;
      byte_cnt   <= 11'd0;
      crc        <= CRC_INIT;
      held       <= 8'd0;
      held_vld   <= 1'b0;
      align_pend <= 1'b0;
      len_pend   <= 1'b0;
      data_r     <= 8'd0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
      crc_ok_r   <= 1'b0;
      align_r    <= 1'b0;
      len_r      <= 1'b0;
      flen_r     <= 11'd0;
    end else begin
      crsdv_q    <= bus.crsdv;
      rxd_q      <= bus.rxd;
      pre_cnt    <= pre_cnt_d;
      dib_idx    <= dib_idx_d;
      shift      <= shift_d;
      byte_cnt   <= byte_cnt_d;
      crc        <= crc_d;
      held       <= held_d;
      held_vld   <= held_vld_d;
      align_pend <= align_pend_d;
      len_pend   <= len_pend_d;
      data_r     <= data_d;
      valid_r    <= valid_d;
      last_r     <= last_d;
      done_r     <= done_d;
      crc_ok_r   <= crc_ok_d;
      align_r    <= align_d;
      len_r      <= len_d;
      flen_r     <= flen_d;
    end
  end

  assign bus.rx_data    = data_r;
  assign bus.rx_valid   = valid_r;
  assign bus.rx_last    = last_r;
  assign bus.frame_done = done_r;
  assign bus.crc_ok     = crc_ok_r;
  assign bus.align_err  = align_r;
  assign bus.len_err    = len_r;
  assign bus.frame_len  = flen_r;

endmodule
